// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// SIGNED_DIV_EN selects the two's-complement build (adds the Fix state).
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        Rest,
        Shift,
        Trial,
        Fix,
        End
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// Switch/button side and display side of the divider, grouped as one bundle.
// SIGNED_DIV_EN does not change the interface.
interface div_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH_DEFAULT) ();

    // Level protocol, no valid/ready: Run high in Rest starts a division and
    // must drop after Done before another start; LoadDivisor is honoured only
    // in Rest with Run low; results are meaningful while Done is high.
    logic             Run;
    logic             LoadDivisor;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Done;
    logic             DivByZero;
    div_state_t       State;

    modport master (
        output Run, LoadDivisor, Din,
        input  Quotient, Remainder, Done, DivByZero, State
    );

    modport slave (
        input  Run, LoadDivisor, Din,
        output Quotient, Remainder, Done, DivByZero, State
    );

endinterface

// File: rtl/div_control.sv
// Divider sequencer: state register, iteration count and per-state strobes.
// With SIGNED_DIV_EN defined the last Trial goes through Fix before End.
module div_control import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic                     B_zero,
    input  logic                     last,
    output logic                     ld,
    output logic                     shift,
    output logic                     trial,
    output logic                     fix,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] count,
    output div_state_t               state
);

    div_state_t next_state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= Rest;
            count <= '0;
        end else begin
            state <= next_state;
            if (ld)
                count <= '0;
            else if (trial && !last)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        ld         = 1'b0;
        shift      = 1'b0;
        trial      = 1'b0;
        fix        = 1'b0;
        done       = 1'b0;
        case (state)
            Rest: begin
                if (Run) begin
                    ld         = 1'b1;
                    // A zero divisor skips the iterations entirely.
                    next_state = B_zero ? End : Shift;
                end
            end
            Shift: begin
                shift      = 1'b1;
                next_state = Trial;
            end
            Trial: begin
                trial = 1'b1;
`ifdef SIGNED_DIV_EN
                next_state = last ? Fix : Shift;
`else
                next_state = last ? End : Shift;
`endif
            end
`ifdef SIGNED_DIV_EN
            Fix: begin
                fix        = 1'b1;
                next_state = End;
            end
`endif
            End: begin
                done = 1'b1;
                if (!Run)
                    next_state = Rest;
            end
            default: next_state = Rest;
        endcase
    end

endmodule

// File: rtl/divider_unit.sv
// Restoring divider datapath (A/Q/B registers) around the div_control sequencer.
// Define SIGNED_DIV_EN for two's-complement operands with sign fix-up.
module divider_unit import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    div_if.slave io
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH:0]   A;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] B;
    logic             dbz;
    logic             ld, shift, trial, fix, done;
    logic             b_zero, last;
    logic [CW-1:0]    count;
    div_state_t       state;

    assign b_zero = (B == '0);
    assign last   = (count == CW'(WIDTH - 1));

`ifdef SIGNED_DIV_EN
    logic s_q, s_b;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction
`endif

    div_control #(.WIDTH(WIDTH)) u_ctrl (
        .Clk    (Clk),
        .Reset  (Reset),
        .Run    (io.Run),
        .B_zero (b_zero),
        .last   (last),
        .ld     (ld),
        .shift  (shift),
        .trial  (trial),
        .fix    (fix),
        .done   (done),
        .count  (count),
        .state  (state)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            A   <= '0;
            Q   <= '0;
            B   <= '0;
            dbz <= 1'b0;
`ifdef SIGNED_DIV_EN
            s_q <= 1'b0;
            s_b <= 1'b0;
`endif
        end else begin
            if (ld) begin
                if (b_zero) begin
                    Q   <= '1;
                    A   <= {1'b0, io.Din};
                    dbz <= 1'b1;
                end else begin
                    A   <= '0;
                    dbz <= 1'b0;
`ifdef SIGNED_DIV_EN
                    Q   <= abs_w(io.Din);
                    B   <= abs_w(B);
                    s_q <= io.Din[WIDTH-1];
                    s_b <= B[WIDTH-1];
`else
                    Q   <= io.Din;
`endif
                end
            end else if (state == Rest && io.LoadDivisor) begin
                B <= io.Din;
            end else if (shift) begin
                {A, Q} <= {A[WIDTH-1:0], Q, 1'b0};
            end else if (trial) begin
                // Trial subtract succeeds when it would not borrow.
                if (A >= {1'b0, B}) begin
                    A    <= A - {1'b0, B};
                    Q[0] <= 1'b1;
                end
            end else if (fix) begin
`ifdef SIGNED_DIV_EN
                if (s_q ^ s_b)
                    Q <= ~Q + 1'b1;
                if (s_q)
                    A <= ~A + 1'b1;
`endif
            end
            if (done && !io.Run)
                dbz <= 1'b0;
        end
    end

    assign io.Quotient  = Q;
    assign io.Remainder = A[WIDTH-1:0];
    assign io.Done      = done;
    assign io.DivByZero = dbz;
    assign io.State     = state;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized divisions. Honours SIGNED_DIV_EN.
module tb_divider_unit;
    import div_pkg::*;

    localparam int W = DIV_WIDTH_DEFAULT;
`ifdef SIGNED_DIV_EN
    localparam int LAT = 2 * W + 1;
`else
    localparam int LAT = 2 * W;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    div_if #(.WIDTH(W)) io ();

    divider_unit #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .io    (io)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = dividing, 2 = result shown
    bit           m_init = 1'b0;
    int           m_mode = 0;
    int           m_left = 0;
    logic [W-1:0] m_b, m_q, m_r;
    bit           m_dbz;

    task automatic model_start(input logic [W-1:0] din);
        if (m_b == '0) begin
            m_q    = '1;
            m_r    = din;
            m_dbz  = 1'b1;
            m_mode = 2;
        end else begin
`ifdef SIGNED_DIV_EN
            int sd, sv;
            sd  = int'($signed(din));
            sv  = int'($signed(m_b));
            m_q = W'(sd / sv);
            m_r = W'(sd % sv);
            m_b = W'((sv < 0) ? -sv : sv);
`else
            m_q = din / m_b;
            m_r = din % m_b;
`endif
            m_dbz  = 1'b0;
            m_left = LAT;
            m_mode = 1;
        end
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            m_init = 1'b1;
            m_mode = 0;
            m_b    = '0;
            m_q    = '0;
            m_r    = '0;
            m_dbz  = 1'b0;
        end else begin
            case (m_mode)
                0: if (io.Run) model_start(io.Din);
                   else if (io.LoadDivisor) m_b = io.Din;
                1: begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
                default: if (!io.Run) begin
                    m_mode = 0;
                    m_dbz  = 1'b0;
                end
            endcase
        end
    end

    always @(negedge Clk) begin
        if (m_init) begin
            chk("done", io.Done, (m_mode == 2));
            chk("div_by_zero", io.DivByZero, m_dbz);
            if (m_mode != 1) begin
                chk("quotient", io.Quotient, m_q);
                chk("remainder", io.Remainder, m_r);
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic load_b(input logic [W-1:0] v);
        io.LoadDivisor = 1'b1;
        io.Din = v;
        tick();
        io.LoadDivisor = 1'b0;
    endtask

    task automatic do_div(input logic [W-1:0] din, input int hold, input bit with_load, output int lat);
        io.Din = din;
        io.Run = 1'b1;
        io.LoadDivisor = with_load;
        lat = 0;
        do begin
            tick();
            lat++;
            io.Din = W'($urandom);
            io.LoadDivisor = 1'($urandom_range(0, 1));
        end while (!io.Done && lat < 40);
        if (!io.Done) begin
            checks++;
            errors++;
            $display("FAIL timeout: Done still %0b after %0d cycles, required 1", io.Done, lat);
        end
        repeat (hold) tick();
        if (hold > 0) chk("held_in_end", io.Done, 1);
        io.Run = 1'b0;
        io.LoadDivisor = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        logic [W-1:0] b, d;
        io.Run = 1'b0;
        io.LoadDivisor = 1'b0;
        io.Din = '0;
        repeat (2) tick();
        Reset = 1'b0;
        chk("reset_q", io.Quotient, 0);
        chk("reset_r", io.Remainder, 0);
        chk("reset_done", io.Done, 0);

        load_b(8'd7);
        do_div(8'd100, 0, 1'b0, lat);
        chk("latency", lat, LAT + 1);
`ifndef SIGNED_DIV_EN
        chk("q_100_7", io.Quotient, 8'h0E);
        chk("r_100_7", io.Remainder, 8'h02);

        load_b(8'd1);
        do_div(8'd255, 0, 1'b0, lat);
        chk("q_255_1", io.Quotient, 8'hFF);
        chk("r_255_1", io.Remainder, 8'h00);
        load_b(8'd255);
        do_div(8'd254, 0, 1'b0, lat);
        chk("q_254_255", io.Quotient, 8'h00);
        chk("r_254_255", io.Remainder, 8'hFE);
`endif

        load_b(8'd0);
        do_div(8'd5, 0, 1'b0, lat);
        chk("latency_dbz", lat, 1);
        chk("q_dbz", io.Quotient, 8'hFF);
        chk("r_dbz", io.Remainder, 8'h05);

        // Reset in the middle of a division
        load_b(8'd7);
        io.Din = 8'd100;
        io.Run = 1'b1;
        repeat (6) tick();
        chk("mid_state", io.State, Trial);
        Reset = 1'b1;
        io.Run = 1'b0;
        tick();
        Reset = 1'b0;
        chk("rst_mid_done", io.Done, 0);
        chk("rst_mid_q", io.Quotient, 0);
        chk("rst_mid_r", io.Remainder, 0);
        load_b(8'd7);
        do_div(8'd100, 10, 1'b0, lat);
        chk("q_restart", io.Quotient, 8'h0E);
        chk("r_restart", io.Remainder, 8'h02);

        // Run and LoadDivisor together: divisor stays 7
        do_div(8'd3, 0, 1'b1, lat);
        chk("q_run_load", io.Quotient, 8'h00);
        chk("r_run_load", io.Remainder, 8'h03);

`ifdef SIGNED_DIV_EN
        load_b(8'd7);
        do_div(8'h9C, 0, 1'b0, lat);
        chk("q_m100_7", io.Quotient, 8'hF2);
        chk("r_m100_7", io.Remainder, 8'hFE);
        load_b(8'hF9);
        do_div(8'd100, 0, 1'b0, lat);
        chk("q_100_m7", io.Quotient, 8'hF2);
        chk("r_100_m7", io.Remainder, 8'h02);
        load_b(8'hFF);
        do_div(8'h80, 0, 1'b0, lat);
        chk("q_m128_m1", io.Quotient, 8'h80);
        chk("r_m128_m1", io.Remainder, 8'h00);
`endif

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0: b = 8'h00;
                1: b = 8'h01;
                2: b = 8'hFF;
                3: b = 8'h80;
                default: b = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: d = 8'h00;
                1: d = 8'hFF;
                2: d = 8'h80;
                default: d = W'($urandom);
            endcase
            load_b(b);
            do_div(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
